// File: rtl/fare_check_arbiter.sv
// fare_check_arbiter: round-robin sharing of one back-end fare-validation port among gate FSMs
module fare_check_arbiter #(
  parameter int N_GATES = 4,
  parameter int ID_W = 16,
  parameter int TIMEOUT = 8,
  localparam int GW = $clog2(N_GATES),
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    maintenance,
  input  logic [N_GATES-1:0]      gate_req,
  input  logic [N_GATES*ID_W-1:0] gate_id,
  output logic [N_GATES-1:0]      gate_ack,
  output logic [N_GATES-1:0]      card_active,
  output logic [N_GATES-1:0]      fund_enough,
  output logic [N_GATES-1:0]      timed_out,
  output logic                    be_req_valid,
  input  logic                    be_req_ready,
  output logic [ID_W-1:0]         be_req_id,
  input  logic                    be_rsp_valid,
  input  logic                    be_rsp_active,
  input  logic                    be_rsp_fund,
  output logic                    busy,
  output logic [GW-1:0]           grant_idx
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] k;
  logic [TW-1:0] timer;
  logic just_acked;
  logic found;
  logic [N_GATES-1:0] avail;
  logic [N_GATES-1:0] sel;
  logic [ID_W-1:0] next_id;
  assign busy = state != IDLE;
  assign sel = N_GATES'(1) << grant_idx;
  assign avail = gate_req & ~(just_acked ? N_GATES'(1) << last_grant : '0);
  // pick the first unmasked requester after last_grant, wrapping, and its card ID
  always_comb begin
    found = 1'b0;
    next_grant = '0;
    k = '0;
    next_id = '0;
    for (int i = 1; i <= N_GATES; i++) begin
      k = GW'((int'(last_grant) + i) % N_GATES);
      if (!found && avail[k]) begin
        found = 1'b1;
        next_grant = k;
      end
    end
    for (int g = 0; g < N_GATES; g++)
      if (GW'(g) == next_grant) next_id = gate_id[g*ID_W +: ID_W];
  end
  // transaction FSM; ack and verdict bits are registered on entry to RESP and last one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= GW'(N_GATES - 1);
      grant_idx <= '0;
      be_req_id <= '0;
      be_req_valid <= 1'b0;
      timer <= '0;
      just_acked <= 1'b0;
      gate_ack <= '0;
      card_active <= '0;
      fund_enough <= '0;
      timed_out <= '0;
    end else begin
      gate_ack <= '0;
      card_active <= '0;
      fund_enough <= '0;
      timed_out <= '0;
      just_acked <= 1'b0;
      case (state)
        IDLE: if (!maintenance && found) begin
          grant_idx <= next_grant;
          be_req_id <= next_id;
          be_req_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (be_req_ready) begin
          be_req_valid <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (be_rsp_valid || timer == TW'(TIMEOUT - 1)) begin
          gate_ack <= sel;
          card_active <= (be_rsp_valid && be_rsp_active) ? sel : '0;
          fund_enough <= (be_rsp_valid && be_rsp_fund) ? sel : '0;
          timed_out <= be_rsp_valid ? '0 : sel;
          state <= RESP;
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          last_grant <= grant_idx;
          just_acked <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fare_check_arbiter.sv
// tb_fare_check_arbiter: scoreboard bench for the fare-check arbiter
module tb_fare_check_arbiter;
  typedef struct {
    logic [3:0] ack;
    logic [3:0] act;
    logic [3:0] fund;
    logic [3:0] tmo;
    int         cyc;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  logic maintenance = 0;
  logic [3:0] gate_req = 0;
  logic [63:0] gate_id = 0;
  logic [3:0] gate_ack, card_active, fund_enough, timed_out;
  logic be_req_valid, be_rsp_valid, be_rsp_active, be_rsp_fund, busy;
  logic be_req_ready = 1;
  logic [15:0] be_req_id;
  logic [1:0] grant_idx;
  logic rsp_auto = 0, a_auto = 0, f_auto = 0;
  logic man_rsp = 0, man_act = 0, man_fund = 0, auto_on = 0;
  logic hs;
  logic [15:0] hid;
  int cyc = 0, checks = 0, errors = 0, n = 0;
  exp_t ack_q[$];
  logic [15:0] id_q[$];
  exp_t e;

  assign be_rsp_valid = rsp_auto | man_rsp;
  assign be_rsp_active = rsp_auto ? a_auto : man_act;
  assign be_rsp_fund = rsp_auto ? f_auto : man_fund;

  fare_check_arbiter dut (
    .clk(clk), .reset(reset), .maintenance(maintenance),
    .gate_req(gate_req), .gate_id(gate_id),
    .gate_ack(gate_ack), .card_active(card_active), .fund_enough(fund_enough),
    .timed_out(timed_out), .be_req_valid(be_req_valid), .be_req_ready(be_req_ready),
    .be_req_id(be_req_id), .be_rsp_valid(be_rsp_valid), .be_rsp_active(be_rsp_active),
    .be_rsp_fund(be_rsp_fund), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int g, input logic [15:0] id);
    gate_id[g*16 +: 16] = id;
  endtask

  task automatic push_ack(input logic [3:0] ack, input logic [3:0] act, input logic [3:0] fund,
                          input logic [3:0] tmo, input int c);
    exp_t x;
    x.ack = ack; x.act = act; x.fund = fund; x.tmo = tmo; x.cyc = c;
    ack_q.push_back(x);
  endtask

  // back end: one cycle after a handshake answer with active=id[0], fund=id[1] when enabled
  initial forever begin
    @(negedge clk);
    hs = be_req_valid && be_req_ready;
    hid = be_req_id;
    @(posedge clk);
    #1;
    rsp_auto = auto_on && hs;
    a_auto = hid[0];
    f_auto = hid[1];
  end

  // monitor: pop expected handshake IDs and acks whenever the DUT presents them
  always @(negedge clk) begin
    if (be_req_valid && be_req_ready) begin
      if (id_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_request: id 'h%0h, none expected (cycle %0d)", be_req_id, cyc);
      end else chk("be_req_id", 64'(be_req_id), 64'(id_q.pop_front()));
    end
    if (gate_ack != 0) begin
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: gate_ack %b, none expected (cycle %0d)", gate_ack, cyc);
      end else begin
        e = ack_q.pop_front();
        chk("ack_verdict", {gate_ack, card_active, fund_enough, timed_out},
            {e.ack, e.act, e.fund, e.tmo});
        if (e.cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    tick(2);
    chk("reset_outputs", {gate_ack, card_active, fund_enough, timed_out, be_req_valid,
        be_req_id, busy, grant_idx}, 0);
    reset = 0;
    tick(2);
    // single valid card on gate 0
    auto_on = 1;
    set_id(0, 16'hBEEF);
    id_q.push_back(16'hBEEF);
    push_ack(4'b0001, 4'b0001, 4'b0001, 4'b0000, cyc + 3);
    gate_req = 4'b0001;
    tick(3);
    gate_req = 0;
    tick(2);
    // round robin with all gates requesting
    reset = 1; tick(2); reset = 0; tick(1);
    set_id(0, 16'hA000); set_id(1, 16'hA001); set_id(2, 16'hA002); set_id(3, 16'hA003);
    id_q.push_back(16'hA000); id_q.push_back(16'hA001); id_q.push_back(16'hA002);
    id_q.push_back(16'hA003); id_q.push_back(16'hA000);
    push_ack(4'b0001, 4'b0000, 4'b0000, 4'b0000, -1);
    push_ack(4'b0010, 4'b0010, 4'b0000, 4'b0000, -1);
    push_ack(4'b0100, 4'b0000, 4'b0100, 4'b0000, -1);
    push_ack(4'b1000, 4'b1000, 4'b1000, 4'b0000, -1);
    push_ack(4'b0001, 4'b0000, 4'b0000, 4'b0000, -1);
    gate_req = 4'b1111;
    n = 0;
    for (int i = 0; i < 80 && n < 5; i++) begin
      tick(1);
      if (gate_ack != 0) n++;
      gate_req = 4'b1111 & ~gate_ack;
    end
    gate_req = 0;
    chk("rr_ack_count", 64'(n), 5);
    tick(2);
    // timeout on gate 2
    auto_on = 0;
    set_id(2, 16'h2222);
    id_q.push_back(16'h2222);
    push_ack(4'b0100, 4'b0000, 4'b0000, 4'b0100, cyc + 10);
    gate_req = 4'b0100;
    tick(10);
    gate_req = 0;
    tick(2);
    // response arriving on the last WAIT cycle beats the timeout
    set_id(1, 16'h1111);
    id_q.push_back(16'h1111);
    push_ack(4'b0010, 4'b0010, 4'b0000, 4'b0000, cyc + 10);
    man_act = 1; man_fund = 0;
    gate_req = 4'b0010;
    tick(9);
    man_rsp = 1;
    tick(1);
    man_rsp = 0;
    gate_req = 0;
    tick(2);
    // back-pressure: request held stable, timer starts only after the handshake
    be_req_ready = 0;
    set_id(3, 16'h3333);
    id_q.push_back(16'h3333);
    push_ack(4'b1000, 4'b0000, 4'b0000, 4'b1000, cyc + 14);
    gate_req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_valid", 64'(be_req_valid), 1);
      chk("bp_id", 64'(be_req_id), 64'h3333);
    end
    be_req_ready = 1;
    tick(9);
    gate_req = 0;
    tick(2);
    // maintenance holds new grants, then releases gate 1
    auto_on = 1;
    maintenance = 1;
    set_id(1, 16'h5557);
    gate_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("maint_hold", {be_req_valid, busy}, 0);
    end
    id_q.push_back(16'h5557);
    push_ack(4'b0010, 4'b0010, 4'b0010, 4'b0000, cyc + 3);
    maintenance = 0;
    tick(1);
    chk("maint_release", {be_req_valid, grant_idx}, {1'b1, 2'd1});
    tick(2);
    gate_req = 0;
    tick(2);
    // maintenance raised during WAIT does not stop the transaction
    set_id(2, 16'h0006);
    id_q.push_back(16'h0006);
    push_ack(4'b0100, 4'b0000, 4'b0100, 4'b0000, cyc + 3);
    gate_req = 4'b0100;
    tick(2);
    maintenance = 1;
    tick(1);
    gate_req = 0;
    tick(2);
    maintenance = 0;
    tick(1);
    // reset in WAIT abandons gate 1; gate 0 then wins over gate 3
    auto_on = 0;
    set_id(1, 16'h0BAD);
    id_q.push_back(16'h0BAD);
    gate_req = 4'b0010;
    tick(3);
    reset = 1;
    gate_req = 4'b1001;
    set_id(0, 16'hC0DE);
    set_id(3, 16'h0003);
    tick(1);
    chk("reset_mid", {gate_ack, card_active, fund_enough, timed_out, be_req_valid,
        be_req_id, busy, grant_idx}, 0);
    reset = 0;
    auto_on = 1;
    id_q.push_back(16'hC0DE);
    id_q.push_back(16'h0003);
    push_ack(4'b0001, 4'b0000, 4'b0001, 4'b0000, -1);
    push_ack(4'b1000, 4'b1000, 4'b1000, 4'b0000, -1);
    n = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      tick(1);
      if (gate_ack != 0) n++;
      gate_req = gate_req & ~gate_ack;
    end
    gate_req = 0;
    chk("post_reset_acks", 64'(n), 2);
    // stray response while idle
    tick(2);
    man_act = 1; man_fund = 1; man_rsp = 1;
    tick(1);
    man_rsp = 0;
    tick(4);
    chk("ack_queue_drained", 64'(ack_q.size()), 0);
    chk("id_queue_drained", 64'(id_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
